// File: rtl/peak_result_streamer.sv
// Streams a packed frame of per-pixel peak results one pixel at a time
// over a valid/ready port, double-buffering one pending frame.
// Ports: clk, res (sync high reset), result_in/result_valid (frame in),
//   out_data/out_pix/out_valid/out_last/out_ready (pixel stream out),
//   busy, overrun (sticky drop flag), frame_cnt (frames fully streamed).
module peak_result_streamer #(
  parameter int NP   = 16,
  parameter int PIX  = 4,
  parameter int IDXW = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NP*PIX-1:0] result_in,
  input  logic              result_valid,
  output logic [NP-1:0]     out_data,
  output logic [IDXW-1:0]   out_pix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       frame_cnt
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(PIX - 1);

  state_t              state_q, state_d;
  logic [NP*PIX-1:0]   active_q, active_d;
  logic [NP*PIX-1:0]   shadow_q, shadow_d;
  logic                sfull_q, sfull_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                ovr_q, ovr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [NP-1:0]       data_q, data_d;
  logic                last_q, last_d;

  logic xfer;
  logic xlast;

  assign xfer  = (state_q == STREAM) && out_ready;
  assign xlast = xfer && (idx_q == LAST);

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    shadow_d = shadow_q;
    sfull_d  = sfull_q;
    idx_d    = idx_q;
    ovr_d    = ovr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (result_valid) begin
          active_d = result_in;
          idx_d    = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (xlast) begin
          cnt_d = cnt_q + 16'd1;
          idx_d = '0;
          if (sfull_q) begin
            // Pending frame follows with no bubble; a
            // simultaneous new frame refills the shadow.
            active_d = shadow_q;
            if (result_valid) shadow_d = result_in;
            else              sfull_d  = 1'b0;
          end else if (result_valid) begin
            active_d = result_in;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) idx_d = idx_q + 1'b1;
          if (result_valid) begin
            if (sfull_q) ovr_d = 1'b1;
            shadow_d = result_in;
            sfull_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = '0;
    last_d = 1'b0;
    if (state_d == STREAM) begin
      last_d = (idx_d == LAST);
      for (int k = 0; k < PIX; k++) begin
        if (idx_d == IDXW'(k)) data_d = active_d[k*NP +: NP];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      active_q <= '0;
      shadow_q <= '0;
      sfull_q  <= 1'b0;
      idx_q    <= '0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      sfull_q  <= sfull_d;
      idx_q    <= idx_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_pix   = idx_q;
  assign out_valid = (state_q == STREAM);
  assign out_last  = last_q;
  assign busy      = (state_q == STREAM);
  assign overrun   = ovr_q;
  assign frame_cnt = cnt_q;

endmodule

// File: doc/peak_result_streamer.md
PEAK_RESULT_STREAMER -- requirements
Module: peak_result_streamer

Interface
REQ-001 Parameter: NP, 16, width of one per-pixel peak result (matches Np).
REQ-002 Parameter: PIX, 4, pixels per result frame (matches PIXEL_NUM_PER_RAM).
REQ-003 Parameter: IDXW, 8, width of the pixel index output.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: res  input  1  reset, synchronous, active-high.
REQ-006 Port: result_in  input  NP*PIX  packed peak results; pixel k occupies bits [k*NP +: NP].
REQ-007 Port: result_valid  input  1  one-cycle pulse; result_in holds a complete new frame.
REQ-008 Port: out_data  output  NP  peak result of the currently presented pixel.
REQ-009 Port: out_pix  output  IDXW  index (0..PIX-1) of the presented pixel.
REQ-010 Port: out_valid  output  1  out_data/out_pix/out_last are valid.
REQ-011 Port: out_ready  input  1  consumer accepts; a transfer is out_valid AND out_ready in the same cycle.
REQ-012 Port: out_last  output  1  high while out_pix == PIX-1.
REQ-013 Port: busy  output  1  high whenever the state is STREAM.
REQ-014 Port: overrun  output  1  sticky; a buffered frame was overwritten before being streamed.
REQ-015 Port: frame_cnt  output  16  number of frames fully streamed, wraps modulo 2^16.

Function
REQ-016 The block SHALL hold two frame registers, ACTIVE (being streamed) and SHADOW (pending), plus a shadow_full flag.
REQ-017 States SHALL be IDLE and STREAM; out_valid SHALL equal (state == STREAM).
REQ-018 IDLE + result_valid: capture result_in into ACTIVE, set index to 0, and enter STREAM; out_valid SHALL rise on the next cycle (latency 1 clock).
REQ-019 In STREAM, out_data SHALL equal ACTIVE[index] and out_pix SHALL equal index, both registered.
REQ-020 While out_valid is high and out_ready is low, out_data, out_pix and out_last SHALL hold stable.
REQ-021 A transfer with index < PIX-1 SHALL increment index by 1 with no bubble.
REQ-022 A transfer with index == PIX-1 (last) SHALL increment frame_cnt, then:
- if shadow_full: move SHADOW to ACTIVE, clear shadow_full, set index 0, stay in STREAM (no bubble);
- else: enter IDLE.
REQ-023 STREAM + result_valid with no last transfer:
- shadow empty: load SHADOW and set shadow_full;
- shadow full: overwrite SHADOW with the newer frame and set overrun to 1.
REQ-024 Last transfer + result_valid in the same cycle, shadow empty: load result_in directly into ACTIVE, set index 0, stay in STREAM; overrun unchanged.
REQ-025 Last transfer + result_valid in the same cycle, shadow full: move SHADOW to ACTIVE and load result_in into SHADOW; shadow_full stays 1; overrun unchanged.
REQ-026 result_valid during IDLE SHALL never set overrun.
REQ-027 Once set, overrun SHALL stay 1 until res.
REQ-028 result_in SHALL be sampled only in cycles where result_valid is high.

Reset
REQ-029 When res is high at a clock edge, the block SHALL clear:
- out_data, out_pix, out_valid, out_last, busy, overrun and frame_cnt to 0;
- shadow_full to 0;
- state to IDLE.
REQ-030 A reset during streaming SHALL discard ACTIVE and SHADOW; after res deasserts, no transfer occurs until a new result_valid arrives.
REQ-031 result_valid asserted in the same cycle as res SHALL be ignored.

Verification
REQ-032 Frame {0x0011,0x0022,0x0033,0x0044}, out_ready held 1 -> out_valid rises 1 cycle after result_valid; out_data 0x0011..0x0044 with out_pix 0..3 on consecutive cycles; out_last only with 0x0044; frame_cnt=1; back to IDLE.
REQ-033 Same frame, out_ready toggled 1,0,0,1,1,0,1 -> exactly 4 transfers in order 0x0011..0x0044; outputs stable during every stall.
REQ-034 Frame A={1,2,3,4}, then frame B={5,6,7,8} pulsed at A index 1, out_ready=1 -> 8 back-to-back transfers 1..8, no gap; frame_cnt=2; overrun=0.
REQ-035 out_ready=0; frames A, B, C pulsed in order -> A streams, then C (B dropped); overrun=1 and remains 1 after idle; frame_cnt=2 once both frames drain.
REQ-036 result_valid with frame B in the same cycle as A's last transfer, shadow empty -> next cycle out_pix=0 with B[0]; overrun=0.
REQ-037 res pulsed at A index 2 -> next cycle all outputs 0; out_valid stays 0 until the next result_valid; frame_cnt restarts at 0.
